exp7_unidade_controle: RTL and testbench



---
 rtl/exp7_unidade_controle.sv | 228 ++++++++++++++++++++++
 tb/tb_exp7_unidade_controle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp7_unidade_controle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exp7_unidade_controle                                         |
// | Purpose  : Moore control unit for the exp7 memory game (Genius-style).   |
// |            Plays the stored sequence, collects and checks the player's   |
// |            moves, appends a new move per round in modo2, and reports     |
// |            victory, defeat and timeout.                                  |
// | Config   : TIMEOUT_EN - when defined, ESPERA/ESPERA_NOVA run the move    |
// |            timer and may expire into TIMEOUT; when undefined they wait   |
// |            indefinitely and TIMEOUT is unreachable.                      |
// | Ports    : clock, reset (sync, active-low), iniciar                      |
// |            conditions : jogada_feita, jogada_correta,                    |
// |                         enderecoIgualRodada                              |
// |            config     : nivel_jogadas_reg, nivel_tempo_reg, modo2_reg    |
// |            flags      : meioCR, fimCR, meioTM, fimTM, meioTempo,         |
// |                         fimTempo                                         |
// |            strobes    : zeraR, registraR, zeraC, contaC, registraN,      |
// |                         contaTempo, zeraCR, zeraTempo, contaCR, zeraTM,  |
// |                         contaTM, ativa_leds_mem, ativa_leds_jog, toca,   |
// |                         gravaM                                           |
// |            status     : pronto, ganhou, perdeu, timeout, db_estado       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module exp7_unidade_controle #(
  parameter int ESTADO_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada_feita,
  input  logic                jogada_correta,
  input  logic                enderecoIgualRodada,
  input  logic                nivel_jogadas_reg,
  input  logic                nivel_tempo_reg,
  input  logic                modo2_reg,
  input  logic                meioCR,
  input  logic                fimCR,
  input  logic                meioTM,
  input  logic                fimTM,
  input  logic                meioTempo,
  input  logic                fimTempo,
  output logic                zeraR,
  output logic                registraR,
  output logic                zeraC,
  output logic                contaC,
  output logic                registraN,
  output logic                contaTempo,
  output logic                zeraCR,
  output logic                zeraTempo,
  output logic                contaCR,
  output logic                zeraTM,
  output logic                contaTM,
  output logic                ativa_leds_mem,
  output logic                ativa_leds_jog,
  output logic                toca,
  output logic                gravaM,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

  typedef enum logic [4:0] {
    INICIAL        = 5'h00,
    PREPARACAO     = 5'h01,
    INICIO_RODADA  = 5'h02,
    MOSTRA         = 5'h03,
    INTERVALO      = 5'h04,
    PROXIMO_MOSTRA = 5'h05,
    ZERA_END       = 5'h06,
    ESPERA         = 5'h07,
    REGISTRA       = 5'h08,
    FEEDBACK       = 5'h09,
    COMPARA        = 5'h0A,
    PROXIMA_JOGADA = 5'h0B,
    PROXIMA_NOVA   = 5'h0C,
    ESPERA_NOVA    = 5'h0D,
    GRAVA_NOVA     = 5'h0E,
    PROXIMA_RODADA = 5'h0F,
    GANHOU         = 5'h10,
    PERDEU         = 5'h11,
    TIMEOUT        = 5'h12
  } estado_t;

  estado_t estado;
  estado_t proximo;

  // Last round is 16 (fimCR) or 8 (meioCR) depending on the difficulty level.
  logic ultima;
  assign ultima = nivel_jogadas_reg ? fimCR : meioCR;

`ifdef TIMEOUT_EN
  // Fast timing level gives the player half the move time.
  logic expirou;
  assign expirou = nivel_tempo_reg ? meioTempo : fimTempo;
`else
  // Timer flags have no effect when the timeout feature is compiled out.
  logic unused_tempo;
  assign unused_tempo = ^{nivel_tempo_reg, meioTempo, fimTempo};
`endif

  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo        = estado;
    zeraR          = 1'b0;
    registraR      = 1'b0;
    zeraC          = 1'b0;
    contaC         = 1'b0;
    registraN      = 1'b0;
    contaTempo     = 1'b0;
    zeraCR         = 1'b0;
    zeraTempo      = 1'b0;
    contaCR        = 1'b0;
    zeraTM         = 1'b0;
    contaTM        = 1'b0;
    ativa_leds_mem = 1'b0;
    ativa_leds_jog = 1'b0;
    toca           = 1'b0;
    gravaM         = 1'b0;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    timeout        = 1'b0;
    unique case (estado)
      INICIAL: if (iniciar) proximo = PREPARACAO;
      PREPARACAO: begin
        zeraR = 1'b1; zeraC = 1'b1; zeraCR = 1'b1;
        zeraTempo = 1'b1; zeraTM = 1'b1; registraN = 1'b1;
        proximo = INICIO_RODADA;
      end
      INICIO_RODADA: begin
        zeraC = 1'b1; zeraTM = 1'b1;
        proximo = MOSTRA;
      end
      MOSTRA: begin
        ativa_leds_mem = 1'b1; toca = 1'b1; contaTM = 1'b1;
        if (meioTM) proximo = INTERVALO;
      end
      INTERVALO: begin
        contaTM = 1'b1;
        if (fimTM) proximo = enderecoIgualRodada ? ZERA_END : PROXIMO_MOSTRA;
      end
      PROXIMO_MOSTRA: begin
        contaC = 1'b1; zeraTM = 1'b1;
        proximo = MOSTRA;
      end
      ZERA_END: begin
        zeraC = 1'b1; zeraTempo = 1'b1;
        proximo = ESPERA;
      end
      // A move in the same cycle as expiry wins: the player beat the clock.
      ESPERA: begin
`ifdef TIMEOUT_EN
        contaTempo = 1'b1;
        if (jogada_feita) proximo = REGISTRA;
        else if (expirou) proximo = TIMEOUT;
`else
        if (jogada_feita) proximo = REGISTRA;
`endif
      end
      REGISTRA: begin
        registraR = 1'b1; zeraTempo = 1'b1; zeraTM = 1'b1;
        proximo = FEEDBACK;
      end
      FEEDBACK: begin
        ativa_leds_jog = 1'b1; toca = 1'b1; contaTM = 1'b1;
        if (meioTM) proximo = COMPARA;
      end
      COMPARA: begin
        if (!jogada_correta)           proximo = PERDEU;
        else if (!enderecoIgualRodada) proximo = PROXIMA_JOGADA;
        else if (ultima)               proximo = GANHOU;
        else if (modo2_reg)            proximo = PROXIMA_NOVA;
        else                           proximo = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: begin
        contaC = 1'b1; zeraTempo = 1'b1;
        proximo = ESPERA;
      end
      PROXIMA_NOVA: begin
        contaC = 1'b1; zeraTempo = 1'b1;
        proximo = ESPERA_NOVA;
      end
      ESPERA_NOVA: begin
`ifdef TIMEOUT_EN
        contaTempo = 1'b1;
        if (jogada_feita) proximo = GRAVA_NOVA;
        else if (expirou) proximo = TIMEOUT;
`else
        if (jogada_feita) proximo = GRAVA_NOVA;
`endif
      end
      GRAVA_NOVA: begin
        gravaM = 1'b1; registraR = 1'b1;
        proximo = PROXIMA_RODADA;
      end
      PROXIMA_RODADA: begin
        contaCR = 1'b1; zeraC = 1'b1; zeraTM = 1'b1; zeraTempo = 1'b1;
        proximo = MOSTRA;
      end
      GANHOU: begin
        pronto = 1'b1; ganhou = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
      PERDEU: begin
        pronto = 1'b1; perdeu = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
`ifdef TIMEOUT_EN
      TIMEOUT: begin
        pronto = 1'b1; perdeu = 1'b1; timeout = 1'b1;
        if (iniciar) proximo = PREPARACAO;
      end
`endif
      // Unused codes recover to INICIAL.
      default: proximo = INICIAL;
    endcase
  end

  assign db_estado = ESTADO_W'(estado);

endmodule
`default_nettype wire

// File: tb/tb_exp7_unidade_controle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exp7_unidade_controle                                      |
// | Purpose  : Self-checking bench for exp7_unidade_controle. Each cycle the |
// |            expected state and output vector are pushed to a scoreboard   |
// |            queue when stimulus is driven and popped after the edge.      |
// | Config   : honours TIMEOUT_EN the same way as the design.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_exp7_unidade_controle;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
  logic nivel_jogadas_reg, nivel_tempo_reg, modo2_reg;
  logic meioCR, fimCR, meioTM, fimTM, meioTempo, fimTempo;
  logic zeraR, registraR, zeraC, contaC, registraN, contaTempo, zeraCR;
  logic zeraTempo, contaCR, zeraTM, contaTM, ativa_leds_mem, ativa_leds_jog;
  logic toca, gravaM, pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;

  always #5 clock = ~clock;

  exp7_unidade_controle #(.ESTADO_W(5)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .enderecoIgualRodada(enderecoIgualRodada),
    .nivel_jogadas_reg(nivel_jogadas_reg), .nivel_tempo_reg(nivel_tempo_reg),
    .modo2_reg(modo2_reg), .meioCR(meioCR), .fimCR(fimCR),
    .meioTM(meioTM), .fimTM(fimTM), .meioTempo(meioTempo), .fimTempo(fimTempo),
    .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
    .registraN(registraN), .contaTempo(contaTempo), .zeraCR(zeraCR),
    .zeraTempo(zeraTempo), .contaCR(contaCR), .zeraTM(zeraTM),
    .contaTM(contaTM), .ativa_leds_mem(ativa_leds_mem),
    .ativa_leds_jog(ativa_leds_jog), .toca(toca), .gravaM(gravaM),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .db_estado(db_estado)
  );

  // Output vector bit positions.
  localparam int B_ZR = 18, B_RR = 17, B_ZC = 16, B_CC = 15, B_RN = 14;
  localparam int B_CT = 13, B_ZCR = 12, B_ZT = 11, B_CCR = 10, B_ZTM = 9;
  localparam int B_CTM = 8, B_LM = 7, B_LJ = 6, B_TO = 5, B_GM = 4;
  localparam int B_PR = 3, B_GA = 2, B_PE = 1, B_TMO = 0;

  logic [18:0] outs;
  assign outs = {zeraR, registraR, zeraC, contaC, registraN, contaTempo, zeraCR,
                 zeraTempo, contaCR, zeraTM, contaTM, ativa_leds_mem,
                 ativa_leds_jog, toca, gravaM, pronto, ganhou, perdeu, timeout};

  typedef struct packed {
    logic [4:0]  st;
    logic [18:0] o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_contaCR = 0;
  int   n_gravaM = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected strobes per state, straight from the state table.
  function automatic logic [18:0] outs_of(input logic [4:0] s);
    logic [18:0] o;
    o = '0;
    case (s)
      5'h01: begin o[B_ZR]=1; o[B_ZC]=1; o[B_ZCR]=1; o[B_ZT]=1; o[B_ZTM]=1; o[B_RN]=1; end
      5'h02: begin o[B_ZC]=1; o[B_ZTM]=1; end
      5'h03: begin o[B_LM]=1; o[B_TO]=1; o[B_CTM]=1; end
      5'h04: o[B_CTM]=1;
      5'h05: begin o[B_CC]=1; o[B_ZTM]=1; end
      5'h06: begin o[B_ZC]=1; o[B_ZT]=1; end
`ifdef TIMEOUT_EN
      5'h07, 5'h0D: o[B_CT]=1;
`endif
      5'h08: begin o[B_RR]=1; o[B_ZT]=1; o[B_ZTM]=1; end
      5'h09: begin o[B_LJ]=1; o[B_TO]=1; o[B_CTM]=1; end
      5'h0B, 5'h0C: begin o[B_CC]=1; o[B_ZT]=1; end
      5'h0E: begin o[B_GM]=1; o[B_RR]=1; end
      5'h0F: begin o[B_CCR]=1; o[B_ZC]=1; o[B_ZTM]=1; o[B_ZT]=1; end
      5'h10: begin o[B_PR]=1; o[B_GA]=1; end
      5'h11: begin o[B_PR]=1; o[B_PE]=1; end
      5'h12: begin o[B_PR]=1; o[B_PE]=1; o[B_TMO]=1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // One clock: push expectation, advance, pop and compare.
  task automatic cyc(input logic [4:0] st);
    exp_t e;
    exp_t got;
    e.st = st;
    e.o  = outs_of(st);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (contaCR) n_contaCR++;
    if (gravaM)  n_gravaM++;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check($sformatf("estado_%02h", got.st), {27'd0, db_estado}, {27'd0, got.st});
      check($sformatf("outs_%02h", got.st), {13'd0, outs}, {13'd0, got.o});
    end
  endtask

  // From MOSTRA of the last address through to ESPERA.
  task automatic show_to_espera();
    meioTM = 1; cyc(5'h04);
    meioTM = 0; fimTM = 1; enderecoIgualRodada = 1; cyc(5'h06);
    fimTM = 0; cyc(5'h07);
  endtask

  // From ESPERA: make a move, show feedback, land in COMPARA.
  task automatic move_to_compara();
    jogada_feita = 1; cyc(5'h08);
    jogada_feita = 0; cyc(5'h09);
    meioTM = 1; cyc(5'h0A);
    meioTM = 0;
  endtask

  initial begin
    reset = 0; iniciar = 0; jogada_feita = 0; jogada_correta = 1;
    enderecoIgualRodada = 0; nivel_jogadas_reg = 0; nivel_tempo_reg = 0;
    modo2_reg = 0; meioCR = 0; fimCR = 0; meioTM = 0; fimTM = 0;
    meioTempo = 0; fimTempo = 0;

    // Reset and start.
    cyc(5'h00); cyc(5'h00);
    reset = 1; iniciar = 1; cyc(5'h01);
    iniciar = 0; cyc(5'h02); cyc(5'h03);
    cyc(5'h03);  // waits for meioTM

    // Round 0, correct move, no modo2.
    n_contaCR = 0;
    show_to_espera();
    move_to_compara();
    cyc(5'h0F);
    cyc(5'h03);
    check("contaCR_once", n_contaCR, 1);

    // Round 1: two addresses to show, first is not the last.
    meioTM = 1; cyc(5'h04);
    meioTM = 0; fimTM = 1; enderecoIgualRodada = 0; cyc(5'h05);
    fimTM = 0; cyc(5'h03);
    show_to_espera();
    cyc(5'h07);  // idle, no move
    move_to_compara();
    jogada_correta = 0; cyc(5'h11);
    jogada_correta = 1; cyc(5'h11);
    iniciar = 1; cyc(5'h01);
    iniciar = 0; cyc(5'h02); cyc(5'h03);

    // Expiry with fast timing.
    show_to_espera();
    nivel_tempo_reg = 1; meioTempo = 1;
`ifdef TIMEOUT_EN
    cyc(5'h12);
    meioTempo = 0; cyc(5'h12);
    iniciar = 1; cyc(5'h01);
    iniciar = 0; cyc(5'h02); cyc(5'h03);
    show_to_espera();
    meioTempo = 1;
`else
    cyc(5'h07);
    iniciar = 1; cyc(5'h07);  // iniciar ignored while waiting
    iniciar = 0;
`endif

    // Move and expiry together: move wins.
    jogada_feita = 1; cyc(5'h08);
    jogada_feita = 0; meioTempo = 0; cyc(5'h09);
    meioTM = 1; cyc(5'h0A);
    meioTM = 0; enderecoIgualRodada = 0; cyc(5'h0B);
    cyc(5'h07);

    // modo2: last move correct appends a new one.
    modo2_reg = 1; enderecoIgualRodada = 1;
    move_to_compara();
    n_gravaM = 0;
    cyc(5'h0C);
    cyc(5'h0D);
    cyc(5'h0D);
    jogada_feita = 1; cyc(5'h0E);
    jogada_feita = 0; cyc(5'h0F);
    cyc(5'h03);
    check("gravaM_once", n_gravaM, 1);
    modo2_reg = 0;

    // 16-round level: meioCR is not the last round.
    nivel_jogadas_reg = 1; meioCR = 1;
    show_to_espera();
    move_to_compara();
    cyc(5'h0F); cyc(5'h03);
    fimCR = 1;
    show_to_espera();
    move_to_compara();
    cyc(5'h10);
    cyc(5'h10);

    // Restart and reset mid-game in FEEDBACK.
    fimCR = 0; meioCR = 0; nivel_jogadas_reg = 0;
    iniciar = 1; cyc(5'h01);
    iniciar = 0; cyc(5'h02); cyc(5'h03);
    show_to_espera();
    jogada_feita = 1; cyc(5'h08);
    jogada_feita = 0; cyc(5'h09);
    reset = 0; meioTM = 1; cyc(5'h00);
    reset = 1; meioTM = 0; cyc(5'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
